// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational 1-bit full adder cell shared across all bit positions
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer, one full-adder step per clock, LSB first
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;
  logic             last;
  logic [WIDTH-1:0] sum_next;

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (s),
    .cout (co)
  );

  assign last     = (cnt == CW'(WIDTH - 1));
  // Partial sum with the current bit merged in; the full result on the last step.
  assign sum_next = {s, sum_sh};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next[WIDTH-1:1];
          carry  <= co;
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum  <= sum_next;
            cout <= co;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB on this step
            ovf  <= carry ^ co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
